fifo_core: RTL and testbench

FIFO_CORE -- requirements
Module: fifo_core

---
 rtl/fifo_core.sv | 127 ++++++++++++
 tb/tb_fifo_core.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fifo_core.sv
// -----------------------------------------------------------------------------
// fifo_core
//   Eight-entry FIFO datapath driven by an external next-state block. The
//   upstream logic supplies next_state each cycle. This block registers that
//   value as the current state. On the same edge it performs the requested
//   write or read when the fill level allows it.
//
// Ports
//   clk         in   rising-edge clock for all state
//   reset_n     in   asynchronous active-low reset
//   next_state  in   [2:0] requested state (INIT/WRITE/READ/WR_ERROR/RD_ERROR/NO_OP)
//   din         in   [DATA_WIDTH-1:0] write data, taken on a WRITE edge
//   state       out  [2:0] registered current state
//   data_count  out  [3:0] registered number of stored entries (0..8)
//   dout        out  [DATA_WIDTH-1:0] registered read data
//   full        out  data_count == 8
//   empty       out  data_count == 0
//   wr_ack      out  current state is WRITE
//   wr_err      out  current state is WR_ERROR
//   rd_ack      out  current state is READ
//   rd_err      out  current state is RD_ERROR
// -----------------------------------------------------------------------------
module fifo_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            next_state,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [2:0]            state,
  output logic [3:0]            data_count,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  typedef enum logic [2:0] {
    ST_INIT     = 3'b000,
    ST_WRITE    = 3'b001,
    ST_READ     = 3'b010,
    ST_WR_ERROR = 3'b101,
    ST_RD_ERROR = 3'b110,
    ST_NO_OP    = 3'b111
  } state_t;

  localparam logic [3:0] DEPTH = 4'd8;

  state_t                r_state;
  state_t                w_state_next;
  logic [2:0]            r_head;
  logic [2:0]            r_tail;
  logic [3:0]            r_count;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [DATA_WIDTH-1:0] r_mem [0:7];

  logic                  w_wr_en;
  logic                  w_rd_en;

  // Next-state decode: the two unused codes collapse to NO_OP so the state
  // register only ever holds one of the six defined encodings.
  always_comb begin
    w_state_next = ST_NO_OP;
    case (next_state)
      3'b000:  w_state_next = ST_INIT;
      3'b001:  w_state_next = ST_WRITE;
      3'b010:  w_state_next = ST_READ;
      3'b101:  w_state_next = ST_WR_ERROR;
      3'b110:  w_state_next = ST_RD_ERROR;
      3'b111:  w_state_next = ST_NO_OP;
      default: w_state_next = ST_NO_OP;
    endcase
  end

  // An operation happens only when the fill level allows it. A blocked WRITE
  // or READ still updates the state register, but nothing else changes.
  assign w_wr_en = (next_state == ST_WRITE) && (r_count < DEPTH);
  assign w_rd_en = (next_state == ST_READ)  && (r_count != 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Pointers are 3 bits wide, so they wrap 7 -> 0 on their own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= 3'd0;
      r_tail  <= 3'd0;
      r_count <= 4'd0;
      r_dout  <= '0;
    end else begin
      if (w_wr_en) begin
        r_tail  <= r_tail + 3'd1;
        r_count <= r_count + 4'd1;
      end else if (w_rd_en) begin
        r_head  <= r_head + 3'd1;
        r_count <= r_count - 4'd1;
        r_dout  <= r_mem[r_head];
      end
    end
  end

  // Storage has no reset. Every entry is written before it can be read.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_tail] <= din;
    end
  end

  assign state      = r_state;
  assign data_count = r_count;
  assign dout       = r_dout;
  assign full       = (r_count == DEPTH);
  assign empty      = (r_count == 4'd0);
  assign wr_ack     = (r_state == ST_WRITE);
  assign wr_err     = (r_state == ST_WR_ERROR);
  assign rd_ack     = (r_state == ST_READ);
  assign rd_err     = (r_state == ST_RD_ERROR);

endmodule

// File: tb/tb_fifo_core.sv
module tb_fifo_core;

  localparam int DW = 32;

  localparam logic [2:0] NS_INIT  = 3'b000;
  localparam logic [2:0] NS_WRITE = 3'b001;
  localparam logic [2:0] NS_READ  = 3'b010;
  localparam logic [2:0] NS_WERR  = 3'b101;
  localparam logic [2:0] NS_RERR  = 3'b110;
  localparam logic [2:0] NS_NOOP  = 3'b111;

  logic          clk;
  logic          reset_n;
  logic [2:0]    next_state;
  logic [DW-1:0] din;
  logic [2:0]    state;
  logic [3:0]    data_count;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic          wr_ack;
  logic          wr_err;
  logic          rd_ack;
  logic          rd_err;

  fifo_core #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .next_state (next_state),
    .din        (din),
    .state      (state),
    .data_count (data_count),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a queue of stored words, the last read word and the state.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dout;
  logic [2:0]    m_state;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, {29'd0, state}, {29'd0, m_state});
    check({tag, ".count"}, {28'd0, data_count}, DW'(m_q.size()));
    check({tag, ".dout"}, dout, m_dout);
    check({tag, ".full"}, {31'd0, full}, {31'd0, m_q.size() == 8});
    check({tag, ".empty"}, {31'd0, empty}, {31'd0, m_q.size() == 0});
    check({tag, ".status"}, {28'd0, wr_ack, wr_err, rd_ack, rd_err},
          {28'd0, m_state == NS_WRITE, m_state == NS_WERR,
           m_state == NS_READ, m_state == NS_RERR});
  endtask

  // Applies one clock edge with the given request and checks the result.
  task automatic do_edge(input logic [2:0] ns, input logic [DW-1:0] d, input string tag);
    next_state = ns;
    din        = d;
    @(posedge clk);
    if (ns == 3'b011 || ns == 3'b100) m_state = NS_NOOP;
    else                              m_state = ns;
    if (ns == NS_WRITE && m_q.size() < 8) m_q.push_back(d);
    else if (ns == NS_READ && m_q.size() > 0) m_dout = m_q.pop_front();
    #1;
    $display("edge %-8s ns=%03b din=%08h -> state=%03b cnt=%0d dout=%08h",
             tag, ns, d, state, data_count, dout);
    check_all(tag);
  endtask

  // Pulses reset low between edges and checks that the outputs clear at once.
  task automatic reset_pulse();
    reset_n = 1'b0;
    #1;
    m_q.delete();
    m_dout  = '0;
    m_state = NS_INIT;
    $display("reset  -> state=%03b cnt=%0d dout=%08h", state, data_count, dout);
    check_all("reset");
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    next_state = NS_INIT;
    din        = '0;
    m_dout     = '0;
    m_state    = NS_INIT;

    reset_pulse();

    // Fill with 1..8, then drain.
    for (int i = 1; i <= 8; i++) do_edge(NS_WRITE, DW'(i), "fill");
    for (int i = 1; i <= 8; i++) do_edge(NS_READ, '0, "drain");

    // Full guard: WR_ERROR, then a forced WRITE that must be ignored.
    for (int i = 0; i < 8; i++) do_edge(NS_WRITE, DW'(32'h10 + i), "fill2");
    do_edge(NS_WERR, '0, "wr_err");
    do_edge(NS_WRITE, 32'hDEAD_BEEF, "wr_full");
    for (int i = 0; i < 8; i++) do_edge(NS_READ, '0, "drain2");

    // Empty guard from reset.
    reset_pulse();
    do_edge(NS_READ, '0, "rd_empty");
    do_edge(NS_RERR, '0, "rd_err");

    // Pointer wrap: 6 in, 6 out, 5 in, 5 out.
    for (int i = 0; i < 6; i++) do_edge(NS_WRITE, DW'(32'hA0 + i), "wrapw1");
    for (int i = 0; i < 6; i++) do_edge(NS_READ, '0, "wrapr1");
    for (int i = 0; i < 5; i++) do_edge(NS_WRITE, DW'(32'hB0 + i), "wrapw2");
    for (int i = 0; i < 5; i++) do_edge(NS_READ, '0, "wrapr2");

    // Illegal codes and NO_OP.
    do_edge(NS_WRITE, 32'h55, "pre_ill");
    do_edge(3'b011, 32'h66, "ill011");
    do_edge(3'b100, 32'h77, "ill100");
    do_edge(NS_NOOP, 32'h88, "noop");
    do_edge(NS_INIT, 32'h99, "init");

    // Reset in the middle of operation with five entries stored.
    for (int i = 0; i < 4; i++) do_edge(NS_WRITE, DW'(32'hC0 + i), "pre_rst");
    reset_pulse();
    do_edge(NS_NOOP, '0, "post_rst");
    do_edge(NS_READ, '0, "rd_post");

    // Randomized traffic, biased toward reads and writes.
    for (int n = 0; n < 600; n++) begin
      int unsigned r;
      logic [2:0]  ns;
      r = $urandom_range(0, 9);
      if (r < 4)      ns = NS_WRITE;
      else if (r < 8) ns = NS_READ;
      else            ns = 3'($urandom_range(0, 7));
      do_edge(ns, $urandom, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
